alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage arithmetic block of the single-cycle MIPS-subset datapath.
//  Combines ALU-control decode (ALUOp + funct -> 3-bit op), a 32-bit ALU with
//  zero flag, the PC+4 adder, and the branch-target adder (PC+4 + shifted offset).
//  All results are registered once per clk so downstream logic samples stable values.
// PARAMETERS
//  WIDTH  32  datapath width of operands, results, PC and offset
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  rst        in   1      synchronous active-high reset
//  en         in   1      1: capture new results this edge; 0: hold all outputs
//  aluop1     in   1      ALUOp[1] from main control
//  aluop0     in   1      ALUOp[0] from main control
//  funct      in   4      instruction bits [3:0]
//  a          in   WIDTH  ALU operand A (register read data 1)
//  b          in   WIDTH  ALU operand B (output of ALUSrc mux)
//  pc         in   WIDTH  current program counter
//  sextad     in   WIDTH  sign-extended offset, already shifted left 2
//  gout       out  3      registered decoded ALU operation
//  sum        out  WIDTH  registered ALU result
//  zout       out  1      registered zero flag (sum == 0)
//  ovf        out  1      registered signed overflow of add/sub
//  adder1out  out  WIDTH  registered pc + 4
//  adder2out  out  WIDTH  registered (pc + 4) + sextad
// BEHAVIOUR
//  - Reset: on rising clk with rst=1, every output goes to 0 (gout=3'b000);
//    rst has priority over en.
//  - Latency: 1 cycle; inputs present before edge N appear on outputs after edge N.
//  - en=0 and rst=0: all outputs hold previous values.
//  - ALU control decode (combinational, then registered as gout):
//    ALUOp 00 -> 010 (add, lw/sw); 01 -> 110 (sub, beq);
//    11 -> 010 (reserved, treated as add);
//    10 (R-type) by funct: 0000->010 add, 0010->110 sub, 0100->000 and,
//    0101->001 or, 1010->111 slt, 0111->100 nor; any other funct -> 010 add.
//  - ALU ops on decoded code: 000 a&b; 001 a|b; 010 a+b; 110 a-b;
//    111 slt = 1 if signed(a) < signed(b) else 0, computed from the subtract
//    sign XOR its overflow (correct across overflow); 100 ~(a|b);
//    codes 011/101 -> result 0.
//  - Arithmetic is modulo 2^WIDTH; carry out is discarded.
//  - zout = 1 exactly when the WIDTH-bit ALU result is all zero, for every op.
//  - ovf = 1 only for add/sub when operand signs make the signed result wrap;
//    0 for all other ops.
//  - adder1out = pc + 32'h4, wraps at 2^WIDTH (pc=FFFFFFFC -> 0).
//  - adder2out = adder1out + sextad, wraps; negative sextad branches backward.
//  - Adders are independent of ALUOp/funct; all captured on the same edge.
// TESTING
//  - Reset: rst=1 for 2 edges with random inputs -> all outputs 0;
//    deassert rst -> results appear 1 edge later.
//  - R-type add/sub: aluop=10, funct=0000, a=5, b=7 -> gout=010, sum=0000000C, zout=0;
//    funct=0010, a=b=9 -> gout=110, sum=0, zout=1.
//  - Logic/slt: funct=0100 a=F0F0F0F0 b=FF00FF00 -> sum=F000F000;
//    funct=0101 -> sum=FFF0FFF0; funct=1010 a=FFFFFFFF b=1 -> sum=1;
//    a=7FFFFFFF b=80000000 -> sum=0.
//  - Overflow: aluop=00 a=7FFFFFFF b=1 -> sum=80000000, ovf=1;
//    aluop=01 a=80000000 b=1 -> sum=7FFFFFFF, ovf=1.
//  - PC adders: pc=8, sextad=FFFFFFF0 -> adder1out=0000000C, adder2out=FFFFFFFC;
//    pc=FFFFFFFC, sextad=0 -> adder1out=0.
//  - Hold: en=0 while inputs change -> all outputs unchanged; rst=1 with en=0 -> zeros.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Execute-stage bundle: control/operand inputs and registered results of alu_exec_unit.
// Latency: n/a (wiring only).
// Backpressure: none; en gates capture, there is no ready path.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             aluop1;
    logic             aluop0;
    logic [3:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] sextad;
    logic [2:0]       gout;
    logic [WIDTH-1:0] sum;
    logic             zout;
    logic             ovf;
    logic [WIDTH-1:0] adder1out;
    logic [WIDTH-1:0] adder2out;

    // Driver side: control and datapath sources, observes registered results.
    modport master (
        output en, aluop1, aluop0, funct, a, b, pc, sextad,
        input  gout, sum, zout, ovf, adder1out, adder2out
    );

    // Execute unit side.
    modport slave (
        input  en, aluop1, aluop0, funct, a, b, pc, sextad,
        output gout, sum, zout, ovf, adder1out, adder2out
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU-control decode, 32-bit ALU with zero/overflow, PC+4 and branch-target adders.
// Latency: 1 cycle, all results captured together on the rising edge when en=1.
// Backpressure: en=0 holds every output; rst (synchronous) clears and wins over en.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_exec_unit_if.slave bus
);
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-3){1'b0}}, 3'b100};

    logic [2:0]       op_d;
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt_bit;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d;
    logic [WIDTH-1:0] pc4_d;
    logic [WIDTH-1:0] target_d;

    // Decode ALUOp/funct into the 3-bit ALU operation; anything unrecognised falls back to add.
    always_comb begin
        op_d = OP_ADD;
        case ({bus.aluop1, bus.aluop0})
            2'b00:   op_d = OP_ADD;
            2'b01:   op_d = OP_SUB;
            2'b10: begin
                case (bus.funct)
                    4'b0000: op_d = OP_ADD;
                    4'b0010: op_d = OP_SUB;
                    4'b0100: op_d = OP_AND;
                    4'b0101: op_d = OP_OR;
                    4'b1010: op_d = OP_SLT;
                    4'b0111: op_d = OP_NOR;
                    default: op_d = OP_ADD;
                endcase
            end
            default: op_d = OP_ADD;
        endcase
    end

    // Shared arithmetic; signed wrap is detected from operand/result sign bits.
    always_comb begin
        add_res = bus.a + bus.b;
        sub_res = bus.a - bus.b;
        add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_res[WIDTH-1] != bus.a[WIDTH-1]);
        sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_res[WIDTH-1] != bus.a[WIDTH-1]);
        // Sign of a-b corrected by overflow gives a true signed less-than.
        slt_bit = sub_res[WIDTH-1] ^ sub_ovf;
        pc4_d    = bus.pc + PC_STEP;
        target_d = pc4_d + bus.sextad;
    end

    // Select the ALU result; overflow is only meaningful for add and sub.
    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        case (op_d)
            OP_AND: res_d = bus.a & bus.b;
            OP_OR:  res_d = bus.a | bus.b;
            OP_ADD: begin
                res_d = add_res;
                ovf_d = add_ovf;
            end
            OP_SUB: begin
                res_d = sub_res;
                ovf_d = sub_ovf;
            end
            OP_SLT: res_d = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_NOR: res_d = ~(bus.a | bus.b);
            default: res_d = '0;
        endcase
    end

    // Output register: reset clears, en captures, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.gout      <= 3'b000;
            bus.sum       <= '0;
            bus.zout      <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.adder1out <= '0;
            bus.adder2out <= '0;
        end else if (bus.en) begin
            bus.gout      <= op_d;
            bus.sum       <= res_d;
            bus.zout      <= (res_d == '0);
            bus.ovf       <= ovf_d;
            bus.adder1out <= pc4_d;
            bus.adder2out <= target_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed and random stimulus, expected results queued by a reference model.
// Latency: checks each registered result one edge after its inputs were applied.
// Backpressure: en and rst are exercised; the model holds or clears its state to match.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;

    alu_exec_unit_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  gout;
        logic [31:0] sum;
        logic        zout;
        logic        ovf;
        logic [31:0] adder1out;
        logic [31:0] adder2out;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t model_state;
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Decode table written straight from the ALU-control rules.
    function automatic logic [2:0] ref_decode(input logic op1, input logic op0, input logic [3:0] f);
        if (op1 && !op0) begin
            case (f)
                4'b0000: return 3'b010;
                4'b0010: return 3'b110;
                4'b0100: return 3'b000;
                4'b0101: return 3'b001;
                4'b1010: return 3'b111;
                4'b0111: return 3'b100;
                default: return 3'b010;
            endcase
        end
        if (!op1 && op0) return 3'b110;
        return 3'b010;
    endfunction

    // Next state of the registered outputs, using wide signed arithmetic for overflow and slt.
    function automatic exp_t ref_step(input exp_t prev, input logic r, input logic e,
                                      input logic op1, input logic op0, input logic [3:0] f,
                                      input logic [31:0] av, input logic [31:0] bv,
                                      input logic [31:0] pcv, input logic [31:0] sx);
        exp_t   n;
        longint sa, sb, wide;
        logic [31:0] pc4;
        n = prev;
        if (r) begin
            n.gout = 3'b000; n.sum = 32'h0; n.zout = 1'b0; n.ovf = 1'b0;
            n.adder1out = 32'h0; n.adder2out = 32'h0;
            return n;
        end
        if (!e) return n;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        n.gout = ref_decode(op1, op0, f);
        n.ovf  = 1'b0;
        case (n.gout)
            3'b010: begin
                wide  = sa + sb;
                n.sum = wide[31:0];
                n.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            3'b110: begin
                wide  = sa - sb;
                n.sum = wide[31:0];
                n.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            3'b000:  n.sum = av & bv;
            3'b001:  n.sum = av | bv;
            3'b100:  n.sum = ~(av | bv);
            3'b111:  n.sum = (sa < sb) ? 32'd1 : 32'd0;
            default: n.sum = 32'h0;
        endcase
        n.zout = (n.sum == 32'h0);
        pc4 = pcv + 32'd4;
        n.adder1out = pc4;
        n.adder2out = pc4 + sx;
        return n;
    endfunction

    // Apply one cycle of inputs at the falling edge and queue what the next rising edge must produce.
    task automatic drive(input logic r, input logic e, input logic op1, input logic op0,
                         input logic [3:0] f, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] pcv, input logic [31:0] sx, input string nm);
        exp_t x;
        @(negedge clk);
        rst = r; bus.en = e; bus.aluop1 = op1; bus.aluop0 = op0; bus.funct = f;
        bus.a = av; bus.b = bv; bus.pc = pcv; bus.sextad = sx;
        model_state = ref_step(model_state, r, e, op1, op0, f, av, bv, pcv, sx);
        x = model_state;
        x.name = nm;
        exp_q.push_back(x);
    endtask

    // Monitor: after every rising edge, compare the DUT outputs against the oldest queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                n_cmp++;
                if (bus.gout !== x.gout || bus.sum !== x.sum || bus.zout !== x.zout ||
                    bus.ovf !== x.ovf || bus.adder1out !== x.adder1out || bus.adder2out !== x.adder2out) begin
                    n_fail++;
                    $display("FAIL %s: got gout=%b sum=%h z=%b ovf=%b a1=%h a2=%h, expected gout=%b sum=%h z=%b ovf=%b a1=%h a2=%h",
                             x.name, bus.gout, bus.sum, bus.zout, bus.ovf, bus.adder1out, bus.adder2out,
                             x.gout, x.sum, x.zout, x.ovf, x.adder1out, x.adder2out);
                end
            end
        end
    end

    initial begin
        logic [3:0]  ftab [8];
        logic [3:0]  f;
        logic [31:0] av, bv;
        int          sel;
        ftab = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b1010, 4'b0111, 4'b1111, 4'b0001};
        model_state = '{3'b000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, ""};
        rst = 1'b1; bus.en = 1'b0; bus.aluop1 = 1'b0; bus.aluop0 = 1'b0; bus.funct = 4'h0;
        bus.a = '0; bus.b = '0; bus.pc = '0; bus.sextad = '0;

        // Reset with random inputs and en high: outputs must stay zero.
        repeat (2) drive(1'b1, 1'b1, 1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom,
                         $urandom, $urandom, "reset");

        // Directed cases.
        drive(0, 1, 1, 0, 4'b0000, 32'd5, 32'd7, 32'd8, 32'hFFFF_FFF0, "rtype_add_pc_back");
        drive(0, 1, 1, 0, 4'b0010, 32'd9, 32'd9, 32'hFFFF_FFFC, 32'h0, "rtype_sub_zero_pc_wrap");
        drive(0, 1, 1, 0, 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h100, 32'h40, "and");
        drive(0, 1, 1, 0, 4'b0101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h104, 32'h0, "or");
        drive(0, 1, 1, 0, 4'b1010, 32'hFFFF_FFFF, 32'h1, 32'h108, 32'h4, "slt_neg_lt_pos");
        drive(0, 1, 1, 0, 4'b1010, 32'h7FFF_FFFF, 32'h8000_0000, 32'h10C, 32'h8, "slt_across_ovf");
        drive(0, 1, 1, 0, 4'b0111, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h110, 32'h0, "nor_zero");
        drive(0, 1, 0, 0, 4'b0101, 32'h7FFF_FFFF, 32'h1, 32'h114, 32'h0, "add_ovf");
        drive(0, 1, 0, 1, 4'b0000, 32'h8000_0000, 32'h1, 32'h118, 32'h0, "sub_ovf");
        drive(0, 1, 1, 1, 4'b0010, 32'h3, 32'h4, 32'h11C, 32'h0, "aluop11_add");
        drive(0, 1, 1, 0, 4'b1100, 32'h10, 32'h20, 32'h120, 32'h0, "undef_funct_add");
        drive(0, 0, 1, 0, 4'b0010, 32'h1234, 32'h5678, 32'h999, 32'h777, "hold_en0");
        drive(0, 0, 0, 1, 4'b0100, 32'hDEAD, 32'hBEEF, 32'h555, 32'h333, "hold_en0_again");
        drive(1, 0, 1, 0, 4'b0000, 32'h1, 32'h1, 32'h4, 32'h4, "rst_with_en0");
        drive(0, 1, 1, 0, 4'b0000, 32'h1, 32'h2, 32'h0, 32'h0, "after_rst");

        // Random traffic, biased toward boundary operands and mostly-enabled cycles.
        for (int i = 0; i < 300; i++) begin
            f   = ftab[$urandom_range(0, 7)];
            sel = $urandom_range(0, 5);
            av  = $urandom;
            bv  = (sel == 0) ? av : (sel == 1) ? 32'h8000_0000 : (sel == 2) ? 32'h7FFF_FFFF : $urandom;
            drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 5) != 0),
                  1'($urandom), 1'($urandom), f, av, bv, $urandom, $urandom, "random");
        end

        // Let the monitor drain; anything left over is a missed comparison.
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
